// File: rtl/dl11_pkg.sv
// dl11_pkg: shared constants for the DL11 console controller.
//   - register indices (bus address bits 2:1)
//   - CSR / RBUF bit positions
//   - transmit FSM state encoding
//   - default interrupt vectors
//   - csr_word(): builds a DONE/READY + IE status word
package dl11_pkg;

  localparam logic [1:0] REG_RCSR = 2'd0;
  localparam logic [1:0] REG_RBUF = 2'd1;
  localparam logic [1:0] REG_XCSR = 2'd2;
  localparam logic [1:0] REG_XBUF = 2'd3;

  localparam int CSR_DONE = 7;   // DONE in RCSR, READY in XCSR
  localparam int CSR_IE   = 6;
  localparam int RBUF_ERR = 15;
  localparam int RBUF_OR  = 14;

  typedef logic [1:0] tx_state_t;
  localparam tx_state_t TX_IDLE  = 2'd0;
  localparam tx_state_t TX_SEND  = 2'd1;
  localparam tx_state_t TX_WBUSY = 2'd2;
  localparam tx_state_t TX_WDONE = 2'd3;

  localparam logic [8:0] DEF_RX_VEC = 9'o060;
  localparam logic [8:0] DEF_TX_VEC = 9'o064;

  function automatic logic [15:0] csr_word(input logic flag, input logic ie);
    logic [15:0] w;
    w           = '0;
    w[CSR_DONE] = flag;
    w[CSR_IE]   = ie;
    return w;
  endfunction

endpackage

// File: rtl/dl11_irq_req.sv
// dl11_irq_req: one interrupt request flip-flop.
//   clk, reset : clock, asynchronous active-high reset
//   cond       : interrupt condition (flag & enable)
//   ack        : acknowledge while this source is being presented
//   req        : request, set on a rising edge of cond, cleared when cond
//                falls or on ack
module dl11_irq_req (
  input  logic clk,
  input  logic reset,
  input  logic cond,
  input  logic ack,
  output logic req
);

  logic cond_q;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cond_q <= 1'b0;
      req    <= 1'b0;
    end else begin
      cond_q <= cond;
      // A fresh rising edge wins over a stale acknowledge.
      if (cond && !cond_q)  req <= 1'b1;
      else if (!cond || ack) req <= 1'b0;
    end
  end

endmodule

// File: rtl/dl11_console_ctrl.sv
// dl11_console_ctrl: DL11-style console registers (RCSR, RBUF, XCSR, XBUF)
// between the bus decoder and a serial_rx/serial_tx pair.
//   bus side : sel, addr[1:0], rd, wr, wdata[15:0] -> rdata[15:0] (registered)
//   receiver : rx_byte[7:0], rx_ready -> rx_read (one-cycle acknowledge)
//   sender   : tx_byte[7:0], tx_send (one-cycle start) <- tx_busy
//   interrupt: irq, irq_vec[8:0] <- iack
module dl11_console_ctrl
  import dl11_pkg::*;
#(
  parameter logic [8:0] RX_VEC = DEF_RX_VEC,
  parameter logic [8:0] TX_VEC = DEF_TX_VEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  input  logic [7:0]  rx_byte,
  input  logic        rx_ready,
  output logic        rx_read,
  output logic [7:0]  tx_byte,
  output logic        tx_send,
  input  logic        tx_busy,
  output logic        irq,
  output logic [8:0]  irq_vec,
  input  logic        iack
);

  logic        rd_en, wr_en, capture, rbuf_rd, xbuf_wr;
  logic        done, ovr, rie, xie, ready;
  logic [7:0]  rx_data;
  tx_state_t   state;
  logic [15:0] rd_mux;
  logic        rx_req, tx_req, rx_ack, tx_ack;
  logic        unused_wdata_bits;

  assign rd_en   = sel & rd;
  assign wr_en   = sel & wr;
  assign rbuf_rd = rd_en && (addr == REG_RBUF);
  assign xbuf_wr = wr_en && (addr == REG_XBUF);
  // rx_ready stays high through the acknowledge cycle; the rx_read guard
  // keeps that cycle from capturing the same byte twice.
  assign capture = rx_ready & ~rx_read;
  assign ready   = (state == TX_IDLE);
  assign tx_send = (state == TX_SEND);

  // Write-data bits with no register behind them.
  assign unused_wdata_bits = ^{wdata[15:8], wdata[5:0]};

  always_comb begin
    // NOTE: default assignment first so no path leaves rd_mux unassigned
    // (which would infer a latch).
    rd_mux = '0;
    case (addr)
      REG_RCSR: rd_mux = csr_word(done, rie);
      REG_RBUF: begin
        rd_mux[RBUF_ERR] = ovr;
        rd_mux[RBUF_OR]  = ovr;
        rd_mux[7:0]      = rx_data;
      end
      REG_XCSR: rd_mux = csr_word(ready, xie);
      default:  rd_mux = '0;   // XBUF is write-only
    endcase
  end

  // Bus read data and interrupt enables.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
      rie   <= 1'b0;
      xie   <= 1'b0;
    end else begin
      if (rd_en) rdata <= rd_mux;
      if (wr_en && addr == REG_RCSR) rie <= wdata[CSR_IE];
      if (wr_en && addr == REG_XCSR) xie <= wdata[CSR_IE];
    end
  end

  // Receive path. A capture coinciding with an RBUF read leaves DONE set
  // (the new byte is unread) but clears OR (the old byte was consumed).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_read <= 1'b0;
      rx_data <= '0;
      done    <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      rx_read <= capture;
      if (capture) begin
        rx_data <= rx_byte;
        done    <= 1'b1;
        ovr     <= (ovr | done) & ~rbuf_rd;
      end else if (rbuf_rd) begin
        done <= 1'b0;
        ovr  <= 1'b0;
      end
    end
  end

  // Transmit sequencer: IDLE -> SEND (one-cycle start) -> WBUSY -> WDONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= TX_IDLE;
      tx_byte <= '0;
    end else begin
      case (state)
        TX_IDLE: if (xbuf_wr) begin
          tx_byte <= wdata[7:0];
          state   <= TX_SEND;
        end
        TX_SEND:  state <= TX_WBUSY;
        TX_WBUSY: if (tx_busy)  state <= TX_WDONE;
        TX_WDONE: if (!tx_busy) state <= TX_IDLE;
      endcase
    end
  end

  // iack retires only the source currently presented; receiver first.
  assign rx_ack = iack & rx_req;
  assign tx_ack = iack & tx_req & ~rx_req;

  dl11_irq_req u_rx_irq (
    .clk   (clk),
    .reset (reset),
    .cond  (done & rie),
    .ack   (rx_ack),
    .req   (rx_req)
  );

  dl11_irq_req u_tx_irq (
    .clk   (clk),
    .reset (reset),
    .cond  (ready & xie),
    .ack   (tx_ack),
    .req   (tx_req)
  );

  assign irq     = rx_req | tx_req;
  assign irq_vec = rx_req ? RX_VEC : (tx_req ? TX_VEC : 9'd0);

endmodule

// File: tb/tb_dl11_console_ctrl.sv
// tb_dl11_console_ctrl: randomized self-checking bench for dl11_console_ctrl.
// Stimulus tasks update a transaction-level model of the console registers
// and push expected read data / transmitted bytes into queues; independent
// monitors pop and compare when the DUT presents rdata or tx_send.
module tb_dl11_console_ctrl;
  import dl11_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel, rd, wr, iack;
  logic [1:0]  addr;
  logic [15:0] wdata, rdata;
  logic [7:0]  rx_byte, tx_byte;
  logic        rx_ready, rx_read, tx_send, tx_busy, irq;
  logic [8:0]  irq_vec;

  always #5 clk = ~clk;

  dl11_console_ctrl dut (
    .clk(clk), .reset(reset), .sel(sel), .addr(addr), .rd(rd), .wr(wr),
    .wdata(wdata), .rdata(rdata), .rx_byte(rx_byte), .rx_ready(rx_ready),
    .rx_read(rx_read), .tx_byte(tx_byte), .tx_send(tx_send),
    .tx_busy(tx_busy), .irq(irq), .irq_vec(irq_vec), .iack(iack)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_done, m_ovr, m_rie, m_xie, m_ready;
  logic [7:0] m_data;
  bit         m_rx_req, m_tx_req, m_rx_cond, m_tx_cond;
  logic [15:0] rd_exp_q[$];
  logic [7:0]  tx_exp_q[$];

  // Requests follow rising edges of (flag & enable) and drop with it.
  function automatic void irq_model();
    bit rc, tc;
    rc = m_done & m_rie;
    tc = m_ready & m_xie;
    if (rc && !m_rx_cond) m_rx_req = 1'b1; else if (!rc) m_rx_req = 1'b0;
    if (tc && !m_tx_cond) m_tx_req = 1'b1; else if (!tc) m_tx_req = 1'b0;
    m_rx_cond = rc;
    m_tx_cond = tc;
  endfunction

  function automatic logic [15:0] model_read(input logic [1:0] a);
    case (a)
      REG_RCSR: return {8'h00, m_done, m_rie, 6'h00};
      REG_RBUF: return {m_ovr, m_ovr, 6'h00, m_data};
      REG_XCSR: return {8'h00, m_ready, m_xie, 6'h00};
      default:  return 16'h0000;
    endcase
  endfunction

  // ---------------- monitors ----------------
  logic rd_q = 1'b0;
  always @(posedge clk) rd_q <= sel & rd;

  always @(negedge clk) begin
    if (rd_q) begin
      if (rd_exp_q.size() == 0) check("rdata unexpected", rd_q, 0);
      else check("rdata", rdata, rd_exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (tx_send) begin
      if (tx_exp_q.size() == 0) check("tx_send unexpected", tx_send, 0);
      else check("tx_byte", tx_byte, tx_exp_q.pop_front());
    end
  end

  // Transmitter: busy one cycle after tx_send, for a random length.
  always @(negedge clk) begin
    if (tx_send) begin
      @(posedge clk); #1 tx_busy = 1'b1;
      repeat ($urandom_range(1, 5)) @(posedge clk);
      #1 tx_busy = 1'b0;
      @(posedge clk);
      m_ready = 1'b1;
      irq_model();
    end
  end

  // ---------------- stimulus tasks (start/end at posedge+1) ----------------
  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_read(input logic [1:0] a);
    rd_exp_q.push_back(model_read(a));
    if (a == REG_RBUF) begin
      m_done = 1'b0;
      m_ovr  = 1'b0;
      irq_model();
    end
    sel = 1'b1; rd = 1'b1; addr = a;
    @(posedge clk); #1;
    sel = 1'b0; rd = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    bit acc;
    acc = (a == REG_XBUF) && m_ready;
    if (a == REG_RCSR) m_rie = d[6];
    if (a == REG_XCSR) m_xie = d[6];
    if (acc) begin
      tx_exp_q.push_back(d[7:0]);
      m_ready = 1'b0;
    end
    irq_model();
    sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; wr = 1'b0;
    if (acc) check("tx_send latency", tx_send, 1);
  endtask

  task automatic rx_handshake(input int exp_wait);
    int k;
    k = 0;
    @(negedge clk);
    while (!rx_read && k < 8) begin
      k++;
      @(negedge clk);
    end
    check("rx_read latency", k, exp_wait);
    @(posedge clk); #1 rx_ready = 1'b0;
    @(negedge clk);
    check("rx_read one pulse", rx_read, 0);
    @(posedge clk); #1;
  endtask

  task automatic rx_deliver(input logic [7:0] b);
    m_ovr  = m_ovr | m_done;
    m_done = 1'b1;
    m_data = b;
    irq_model();
    rx_byte = b; rx_ready = 1'b1;
    rx_handshake(1);
  endtask

  // Byte arrives on the very cycle software reads RBUF.
  task automatic rx_with_read(input logic [7:0] b);
    rd_exp_q.push_back(model_read(REG_RBUF));
    m_done = 1'b1;
    m_ovr  = 1'b0;
    m_data = b;
    irq_model();
    rx_byte = b; rx_ready = 1'b1;
    sel = 1'b1; rd = 1'b1; addr = REG_RBUF;
    @(posedge clk); #1;
    sel = 1'b0; rd = 1'b0;
    rx_handshake(0);
  endtask

  task automatic tx_transfer(input logic [7:0] b, input bit extra);
    int k;
    bus_write(REG_XBUF, {8'h00, b});
    if (extra) bus_write(REG_XBUF, 16'h0042);
    k = 0;
    while (!m_ready && k < 40) begin
      if ($urandom_range(0, 3) == 0) bus_write(REG_XBUF, 16'($urandom));
      else bus_read(REG_XCSR);
      k++;
    end
    if (k >= 40) check("tx ready timeout", k, 0);
    bus_read(REG_XCSR);
  endtask

  task automatic iack_pulse();
    if (m_rx_req) m_rx_req = 1'b0;
    else if (m_tx_req) m_tx_req = 1'b0;
    iack = 1'b1;
    @(posedge clk); #1 iack = 1'b0;
  endtask

  task automatic check_irq(input string tag);
    logic [8:0] ev;
    ev = m_rx_req ? 9'o060 : (m_tx_req ? 9'o064 : 9'd0);
    @(negedge clk);
    check($sformatf("%s irq", tag), irq, m_rx_req | m_tx_req);
    check($sformatf("%s irq_vec", tag), irq_vec, ev);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    sel = 0; rd = 0; wr = 0; addr = 0; wdata = 0; iack = 0;
    rx_byte = 0; rx_ready = 0; tx_busy = 0; reset = 0;
    m_done = 0; m_ovr = 0; m_rie = 0; m_xie = 0; m_ready = 1; m_data = 0;
    m_rx_req = 0; m_tx_req = 0; m_rx_cond = 0; m_tx_cond = 0;

    #2 reset = 1'b1;
    #1;
    check("reset rdata", rdata, 0);
    check("reset rx_read", rx_read, 0);
    check("reset tx_byte", tx_byte, 0);
    check("reset tx_send", tx_send, 0);
    check("reset irq", irq, 0);
    check("reset irq_vec", irq_vec, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    bus_read(REG_RCSR);
    bus_read(REG_XCSR);
    check_irq("after reset");

    rx_deliver(8'h5A);
    bus_read(REG_RCSR);
    bus_read(REG_RBUF);
    bus_read(REG_RCSR);

    rx_deliver(8'h11);
    rx_deliver(8'h22);
    bus_read(REG_RBUF);
    bus_read(REG_RBUF);
    bus_read(REG_RCSR);

    tx_transfer(8'h41, 1'b1);

    bus_write(REG_RCSR, 16'o000100);
    rx_deliver(8'h77);
    bus_write(REG_XCSR, 16'o000100);
    idle_cycles(2);
    check_irq("both pending");
    iack_pulse();
    check_irq("after first iack");
    iack_pulse();
    check_irq("after second iack");
    iack_pulse();
    check_irq("iack while idle");

    rx_deliver(8'h33);
    rx_with_read(8'h44);
    bus_read(REG_RCSR);
    bus_read(REG_RBUF);
    idle_cycles(2);
    check_irq("same-cycle capture");

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0: rx_deliver(8'($urandom));
        1: bus_read(2'($urandom));
        2: bus_write($urandom_range(0, 1) ? REG_XCSR : REG_RCSR, 16'($urandom));
        3: tx_transfer(8'($urandom), 1'b0);
        4: iack_pulse();
        default: bus_write(REG_RBUF, 16'($urandom));
      endcase
      idle_cycles(2);
      check_irq("random");
    end

    idle_cycles(3);
    check("rdata queue drained", rd_exp_q.size(), 0);
    check("tx queue drained", tx_exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dl11_console_ctrl.md
# dl11_console_ctrl

DL11-style console controller that puts the UART byte receiver and transmitter on the processor's register bus as the four standard registers: RCSR, RBUF, XCSR and XBUF. It does three jobs:
- captures received bytes and acknowledges them to the receiver;
- sequences the transmitter's send/busy handshake;
- raises vectored interrupt requests.

It sits between the bus decoder and the serial_rx/serial_tx pair.

## Interface
Parameters:
- RX_VEC, 9'o060: receiver interrupt vector.
- TX_VEC, 9'o064: transmitter interrupt vector.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sel  in  1  register window selected this cycle.
- addr  in  2  register index: 0 RCSR, 1 RBUF, 2 XCSR, 3 XBUF (bus address bits 2:1).
- rd  in  1  one-cycle read strobe, qualified by sel.
- wr  in  1  one-cycle word-write strobe, qualified by sel.
- wdata  in  16  write data.
- rdata  out  16  read data, registered.
- rx_byte  in  8  receiver data.
- rx_ready  in  1  receiver byte available; held until rx_read.
- rx_read  out  1  one-cycle acknowledge to the receiver.
- tx_byte  out  8  byte to the transmitter.
- tx_send  out  1  one-cycle transmit start.
- tx_busy  in  1  transmitter busy; goes high one cycle after tx_send.
- irq  out  1  interrupt request.
- irq_vec  out  9  vector of the pending request.
- iack  in  1  one-cycle interrupt acknowledge.

## Operation
Register bits:
- RCSR: bit7 DONE (read-only), bit6 RIE (read/write); all other bits read 0.
- RBUF: bit15 ERR (equals OR), bit14 OR (overrun), bits7:0 data. Read-only.
- XCSR: bit7 READY (read-only), bit6 XIE (read/write).
- XBUF: write-only; reads return 0.

Receive path:
- Capture when rx_ready=1 and rx_read=0. On capture: load the data latch from rx_byte, set DONE, pulse rx_read on the next cycle.
- Capture while DONE=1: overwrite the latch and set OR.
- RBUF read: clear DONE and OR.
- Capture and RBUF read in the same cycle: the read returns the old byte; the new byte is latched; DONE stays 1; OR ends 0.

Transmit FSM, states IDLE, SEND, WBUSY, WDONE:
- IDLE (READY=1): a write to XBUF latches wdata[7:0] into tx_byte and moves to SEND.
- SEND: tx_send=1 for one cycle, then go to WBUSY.
- WBUSY: wait for tx_busy=1, then go to WDONE.
- WDONE: wait for tx_busy=0, then go to IDLE and set READY.
- READY=0 in SEND, WBUSY and WDONE. Writes to XBUF in these states are ignored.

Interrupts:
- Each source has a request flip-flop: rx_req with condition DONE&RIE, tx_req with condition READY&XIE.
- Set on a 0→1 transition of the condition. This includes setting IE while DONE or READY is already 1.
- Cleared when the condition falls, or by iack while that source is the one being presented.
- irq = rx_req | tx_req. irq_vec = RX_VEC if rx_req, else TX_VEC if tx_req, else 0. Receiver has priority.
- iack with irq=0 is ignored. iack clears only one request.

## Timing
- Reset values: rdata 0, rx_read 0, tx_byte 0, tx_send 0, irq 0, irq_vec 0; DONE 0, OR 0, RIE 0, XIE 0, READY 1; FSM in IDLE; data latch 0.
- Reset asserted mid-transfer returns the FSM to IDLE immediately. The transmitter may still be shifting; no error is flagged.
- Read latency: rdata is valid on the cycle after rd and holds until the next rd. Side effects of a read occur on the rd cycle itself.
- Write latency: a write takes effect on the next edge. An XBUF write produces tx_send exactly 1 cycle later.
- Receive latency: rx_read is asserted the cycle after rx_ready is first seen, and DONE is visible in that same cycle. The capture guard on rx_read prevents a double capture while rx_ready is still high.
- READY returns 1 on the cycle after tx_busy falls.
- irq asserts 1 cycle after its condition rises and drops 1 cycle after iack.

## Structure
- dl11_pkg holds the register index constants, CSR bit positions (DONE=7, IE=6, ERR=15, OR=14), the transmit FSM state enum and the default vectors.
- One sub-module, dl11_irq_req, is instantiated twice. Inputs: clk, reset, cond, ack. Output: req. It contains the edge detector and the request flip-flop.

## Test plan
- Reset → rdata=0, XCSR reads 16'o000200, RCSR reads 0, irq=0.
- Receiver presents 8'h5A → rx_read pulses once; RCSR reads 16'o000200; RBUF reads 16'h005A; a following RCSR read returns 0.
- Two bytes 8'h11 then 8'h22 arrive with no RBUF read in between → RBUF reads 16'hC022; a second RBUF read returns DONE=0 and OR=0.
- Write XBUF=16'h0041 → tx_send one cycle later with tx_byte=8'h41; a second write during busy produces no tx_send; READY returns 1 one cycle after tx_busy falls.
- RIE=1 and XIE=1 with a byte received and transmitter idle → irq_vec=9'o060; after iack, irq_vec=9'o064; after a second iack, irq=0.
- RBUF read on the same cycle as the next capture → old byte returned, DONE stays 1, OR=0.
